// File: rtl/rv_fetch_ctrl.sv
// rv_fetch_ctrl -- instruction fetch controller for a 5-stage RISC-V pipeline.
//
// Issues word-aligned fetch requests to instruction memory, parks a returned
// word in a one-entry skid buffer when the pipeline is stalled, drops data
// from requests that a branch has made stale, and drives the IF/ID register.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   pc_write_i            hazard-unit PC enable (0 = stall)
//   ifid_write_i          hazard-unit IF/ID enable (0 = stall)
//   branch_taken_i        one-cycle EX-stage redirect strobe
//   branch_target_i       redirect address (low two bits ignored)
//   imem_req_o            fetch request
//   imem_addr_o           fetch address, stable until acknowledged
//   imem_ack_i            fetch complete, imem_rdata_i valid this cycle
//   imem_rdata_i          fetched instruction word
//   ifid_pc_o             PC of the instruction in IF/ID
//   ifid_instr_o          instruction in IF/ID
//   ifid_valid_o          IF/ID holds a real instruction
module rv_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_write_i,
  input  logic        ifid_write_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o
);

  // FETCH: request outstanding; HOLD: word parked in skid buffer;
  // DISCARD: request outstanding whose data must be dropped.
  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] reqAddr_q;
  logic        skidValid_q;
  logic [31:0] skidAddr_q;
  logic [31:0] skidInstr_q;
  logic [31:0] ifidPc_q;
  logic [31:0] ifidInstr_q;
  logic        ifidValid_q;

  logic        advance;
  logic [31:0] branchPc;
  logic [1:0]  unusedTgtBits;

  // Both hazard enables must be high for the front end to move forward.
  assign advance       = pc_write_i & ifid_write_i;
  assign branchPc      = {branch_target_i[31:2], 2'b00};
  assign unusedTgtBits = branch_target_i[1:0];

  // Fetch FSM, skid buffer and IF/ID register. A branch overrides everything
  // else; with no ack yet the old request is still in flight on the bus, so
  // its address is kept stable and the FSM waits in DISCARD for the ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      reqAddr_q   <= RESET_PC;
      skidValid_q <= 1'b0;
      skidAddr_q  <= RESET_PC;
      skidInstr_q <= NOP_INSTR;
      ifidPc_q    <= 32'h0000_0000;
      ifidInstr_q <= NOP_INSTR;
      ifidValid_q <= 1'b0;
    end else if (branch_taken_i) begin
      ifidPc_q    <= pc_q;
      ifidInstr_q <= NOP_INSTR;
      ifidValid_q <= 1'b0;
      skidValid_q <= 1'b0;
      pc_q        <= branchPc;
      if ((state_q != HOLD) && !imem_ack_i) begin
        state_q <= DISCARD;
      end else begin
        state_q   <= FETCH;
        reqAddr_q <= branchPc;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ack_i) begin
            if (advance) begin
              ifidPc_q    <= reqAddr_q;
              ifidInstr_q <= imem_rdata_i;
              ifidValid_q <= 1'b1;
              pc_q        <= reqAddr_q + 32'd4;
              reqAddr_q   <= reqAddr_q + 32'd4;
            end else begin
              skidValid_q <= 1'b1;
              skidAddr_q  <= reqAddr_q;
              skidInstr_q <= imem_rdata_i;
              state_q     <= HOLD;
            end
          end else if (ifid_write_i) begin
            ifidPc_q    <= pc_q;
            ifidInstr_q <= NOP_INSTR;
            ifidValid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (advance) begin
            ifidPc_q    <= skidAddr_q;
            ifidInstr_q <= skidInstr_q;
            ifidValid_q <= skidValid_q;
            skidValid_q <= 1'b0;
            pc_q        <= skidAddr_q + 32'd4;
            reqAddr_q   <= skidAddr_q + 32'd4;
            state_q     <= FETCH;
          end
        end
        DISCARD: begin
          if (imem_ack_i) begin
            reqAddr_q <= pc_q;
            state_q   <= FETCH;
          end
          if (ifid_write_i) begin
            ifidPc_q    <= pc_q;
            ifidInstr_q <= NOP_INSTR;
            ifidValid_q <= 1'b0;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  // Request is dropped combinationally during reset so an in-flight fetch is
  // abandoned in the same cycle reset is seen.
  assign imem_req_o   = !rst_i && (state_q != HOLD);
  assign imem_addr_o  = reqAddr_q;
  assign ifid_pc_o    = ifidPc_q;
  assign ifid_instr_o = ifidInstr_q;
  assign ifid_valid_o = ifidValid_q;

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// Self-checking bench for rv_fetch_ctrl: a table of directed vectors, a few
// hand-written multi-cycle sequences, then random stimulus compared against
// a transaction-level reference model.
module tb_rv_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcWrite;
  logic        ifidWrite;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic [31:0] ifidPc;
  logic [31:0] ifidInstr;
  logic        ifidValid;

  int checks = 0;
  int errors = 0;

  rv_fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .pc_write_i     (pcWrite),
    .ifid_write_i   (ifidWrite),
    .branch_taken_i (branchTaken),
    .branch_target_i(branchTarget),
    .imem_req_o     (imemReq),
    .imem_addr_o    (imemAddr),
    .imem_ack_i     (imemAck),
    .imem_rdata_i   (imemRdata),
    .ifid_pc_o      (ifidPc),
    .ifid_instr_o   (ifidInstr),
    .ifid_valid_o   (ifidValid)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the next PC, the address of the request on the
  // bus, whether that request is stale, and an optional parked word.
  logic [31:0] mPc;
  logic [31:0] mReqAddr;
  logic        mStale;
  logic        mParked;
  logic [31:0] mParkAddr;
  logic [31:0] mParkData;
  logic [31:0] mIfPc;
  logic [31:0] mIfInstr;
  logic        mIfValid;

  function automatic logic modelReq(input logic r);
    return !r && !mParked;
  endfunction

  task automatic modelStep(input logic r, input logic pcw, input logic iw,
                           input logic br, input logic [31:0] tgt,
                           input logic ack, input logic [31:0] rd);
    logic [31:0] newPc;
    logic        adv;
    adv   = pcw && iw;
    newPc = tgt & 32'hFFFF_FFFC;
    if (r) begin
      mPc = RESET_PC; mReqAddr = RESET_PC; mStale = 1'b0; mParked = 1'b0;
      mIfPc = 32'd0; mIfInstr = NOP; mIfValid = 1'b0;
    end else if (br) begin
      mIfPc = mPc; mIfInstr = NOP; mIfValid = 1'b0;
      if (!mParked && !ack) begin
        mStale = 1'b1;
      end else begin
        mStale = 1'b0;
        mReqAddr = newPc;
      end
      mParked = 1'b0;
      mPc = newPc;
    end else if (mParked) begin
      if (adv) begin
        mIfPc = mParkAddr; mIfInstr = mParkData; mIfValid = 1'b1;
        mPc = mParkAddr + 32'd4; mReqAddr = mPc; mParked = 1'b0;
      end
    end else if (mStale) begin
      if (ack) begin
        mStale = 1'b0;
        mReqAddr = mPc;
      end
      if (iw) begin
        mIfPc = mPc; mIfInstr = NOP; mIfValid = 1'b0;
      end
    end else if (ack) begin
      if (adv) begin
        mIfPc = mReqAddr; mIfInstr = rd; mIfValid = 1'b1;
        mPc = mReqAddr + 32'd4; mReqAddr = mPc;
      end else begin
        mParked = 1'b1; mParkAddr = mReqAddr; mParkData = rd;
      end
    end else if (iw) begin
      mIfPc = mPc; mIfInstr = NOP; mIfValid = 1'b0;
    end
  endtask

  // Drives one cycle of inputs at the falling edge, advances the model on the
  // rising edge and leaves the caller 1 time unit after that edge.
  task automatic applyStimulus(input logic r, input logic pcw, input logic iw,
                               input logic br, input logic [31:0] tgt,
                               input logic ack, input logic [31:0] rd);
    @(negedge clk);
    rst = r; pcWrite = pcw; ifidWrite = iw; branchTaken = br;
    branchTarget = tgt; imemAck = ack; imemRdata = rd;
    @(posedge clk);
    modelStep(r, pcw, iw, br, tgt, ack, rd);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic eReq, input logic [31:0] eAddr,
                          input logic [31:0] ePc, input logic [31:0] eInstr,
                          input logic eValid);
    checkOutput({tag, " imem_req"},   {31'd0, imemReq},   {31'd0, eReq});
    checkOutput({tag, " imem_addr"},  imemAddr,           eAddr);
    checkOutput({tag, " ifid_pc"},    ifidPc,             ePc);
    checkOutput({tag, " ifid_instr"}, ifidInstr,          eInstr);
    checkOutput({tag, " ifid_valid"}, {31'd0, ifidValid}, {31'd0, eValid});
  endtask

  typedef struct {
    logic        rst, pcw, iw, br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        eReq;
    logic [31:0] eAddr, eIfPc, eIfInstr;
    logic        eIfValid;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic pcw, input logic iw,
                              input logic br, input logic [31:0] tgt,
                              input logic ack, input logic [31:0] rd,
                              input logic eReq, input logic [31:0] eAddr,
                              input logic [31:0] ePc, input logic [31:0] eInstr,
                              input logic eValid);
    vec_t v;
    v.rst = r; v.pcw = pcw; v.iw = iw; v.br = br; v.tgt = tgt; v.ack = ack;
    v.rdata = rd; v.eReq = eReq; v.eAddr = eAddr; v.eIfPc = ePc;
    v.eIfInstr = eInstr; v.eIfValid = eValid;
    return v;
  endfunction

  vec_t vecs[19];

  initial begin
    rst = 1'b1; pcWrite = 1'b1; ifidWrite = 1'b1; branchTaken = 1'b0;
    branchTarget = 32'd0; imemAck = 1'b0; imemRdata = 32'd0;

    //            rst pcw iw br tgt           ack rdata         req addr          ifPc          ifInstr       valid
    vecs[0]  = mk(1, 1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        NOP,          0);
    vecs[1]  = mk(0, 1, 1, 0, 32'h0,        1, 32'hAAAA0000, 1, 32'h4,        32'h0,        32'hAAAA0000, 1);
    vecs[2]  = mk(0, 1, 1, 0, 32'h0,        1, 32'hAAAA0004, 1, 32'h8,        32'h4,        32'hAAAA0004, 1);
    vecs[3]  = mk(0, 1, 1, 0, 32'h0,        1, 32'hAAAA0008, 1, 32'hC,        32'h8,        32'hAAAA0008, 1);
    vecs[4]  = mk(0, 1, 1, 0, 32'h0,        1, 32'hAAAA000C, 1, 32'h10,       32'hC,        32'hAAAA000C, 1);
    vecs[5]  = mk(0, 0, 0, 0, 32'h0,        1, 32'hDEAD0010, 0, 32'h10,       32'hC,        32'hAAAA000C, 1);
    vecs[6]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h10,       32'hC,        32'hAAAA000C, 1);
    vecs[7]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h10,       32'hC,        32'hAAAA000C, 1);
    vecs[8]  = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h14,       32'h10,       32'hDEAD0010, 1);
    vecs[9]  = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h14,       32'h14,       NOP,          0);
    vecs[10] = mk(0, 0, 0, 1, 32'h104,      1, 32'h55,       1, 32'h104,      32'h14,       NOP,          0);
    vecs[11] = mk(0, 1, 1, 0, 32'h0,        1, 32'h11110104, 1, 32'h108,      32'h104,      32'h11110104, 1);
    vecs[12] = mk(0, 1, 1, 1, 32'hFFFFFFFE, 0, 32'h0,        1, 32'h108,      32'h108,      NOP,          0);
    vecs[13] = mk(0, 1, 1, 0, 32'h0,        1, 32'h99,       1, 32'hFFFFFFFC, 32'hFFFFFFFC, NOP,          0);
    vecs[14] = mk(0, 1, 1, 0, 32'h0,        1, 32'h22220000, 1, 32'h0,        32'hFFFFFFFC, 32'h22220000, 1);
    vecs[15] = mk(0, 1, 1, 0, 32'h0,        1, 32'h33330000, 1, 32'h4,        32'h0,        32'h33330000, 1);
    vecs[16] = mk(0, 0, 0, 0, 32'h0,        1, 32'h44,       0, 32'h4,        32'h0,        32'h33330000, 1);
    vecs[17] = mk(0, 0, 0, 1, 32'h80,       0, 32'h0,        1, 32'h80,       32'h4,        NOP,          0);
    vecs[18] = mk(0, 1, 1, 0, 32'h0,        1, 32'h80808080, 1, 32'h84,       32'h80,       32'h80808080, 1);

    $display("[TB] directed vector table");
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].pcw, vecs[i].iw, vecs[i].br, vecs[i].tgt,
                    vecs[i].ack, vecs[i].rdata);
      checkAll($sformatf("vec%0d", i), vecs[i].eReq, vecs[i].eAddr, vecs[i].eIfPc,
               vecs[i].eIfInstr, vecs[i].eIfValid);
    end

    $display("[TB] slow memory with branch during outstanding request");
    applyStimulus(1, 1, 1, 0, 32'h0, 0, 32'h0);
    applyStimulus(0, 1, 1, 1, 32'h40, 1, 32'h1234);
    checkAll("slow0", 1, 32'h40, 32'h0, NOP, 0);
    applyStimulus(0, 1, 1, 1, 32'h203, 0, 32'h0);
    checkAll("slow1", 1, 32'h40, 32'h40, NOP, 0);
    applyStimulus(0, 1, 1, 0, 32'h0, 0, 32'h0);
    checkAll("slow2", 1, 32'h40, 32'h200, NOP, 0);
    applyStimulus(0, 1, 1, 0, 32'h0, 1, 32'hBADBAD40);
    checkAll("slow3", 1, 32'h200, 32'h200, NOP, 0);
    applyStimulus(0, 1, 1, 0, 32'h0, 1, 32'h00C00200);
    checkAll("slow4", 1, 32'h204, 32'h200, 32'h00C00200, 1);

    $display("[TB] reset while request pending");
    applyStimulus(0, 1, 1, 0, 32'h0, 0, 32'h0);
    applyStimulus(1, 1, 1, 0, 32'h0, 1, 32'hBAD0BAD0);
    checkAll("rstmid", 0, RESET_PC, 32'h0, NOP, 0);
    @(negedge clk);
    rst = 1'b0; imemAck = 1'b0;
    #1;
    checkOutput("rstrel imem_req", {31'd0, imemReq}, 32'd1);
    checkOutput("rstrel imem_addr", imemAddr, RESET_PC);

    $display("[TB] random stimulus against reference model");
    for (int n = 0; n < 3000; n++) begin
      logic r, pcw, iw, br, ack;
      r   = ($urandom_range(0, 63) == 0);
      pcw = ($urandom_range(0, 3) != 0);
      iw  = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 9) == 0);
      ack = modelReq(1'b0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) pcw = 1'b1;
      applyStimulus(r, pcw, iw, br, $urandom, ack, $urandom);
      checkAll($sformatf("rand%0d", n), modelReq(r), mReqAddr, mIfPc, mIfInstr, mIfValid);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
